// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_pkg                                                  |
// | Brief    : Shared size encodings, FSM state type and byte-count      |
// |            helper for the load/store data memory.                    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Reserved size 11 counts as four bytes so that it maps onto a word
  // access when the error checks are compiled out.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_array                                                |
// | Brief    : DEPTH-byte storage, one byte-enabled 4-lane write port,   |
// |            combinational 4-byte read port. Byte k powers up as k.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module dmem_array #(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [8*DEPTH-1:0] w_flat;

  for (genvar i = 0; i < DEPTH; i++) begin : g_byte
    // Contents are deliberately outside the reset domain.
    logic [7:0]    r_byte = 8'(i);
    logic [AW-1:0] w_off;
    logic          w_hit;

    assign w_off = AW'(i) - waddr;
    assign w_hit = we && ((w_off == AW'(0) && be[0]) ||
                          (w_off == AW'(1) && be[1]) ||
                          (w_off == AW'(2) && be[2]) ||
                          (w_off == AW'(3) && be[3]));

    // Byte i takes the write lane matching its offset from the base.
    always_ff @(posedge clk) begin
      if (w_hit) begin
        r_byte <= wdata[{w_off[1:0], 3'b000} +: 8];
      end
    end

    assign w_flat[8*i +: 8] = r_byte;
  end

  for (genvar j = 0; j < 4; j++) begin : g_rd
    logic [AW-1:0] w_ra;
    assign w_ra = raddr + AW'(j);
    assign rdata[8*j +: 8] = w_flat[{w_ra, 3'b000} +: 8];
  end

endmodule
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_lsu                                                  |
// | Brief    : Handshaked byte/half/word data memory with configurable   |
// |            latency and load extension. Define DMEM_ALIGN_CHECK_EN    |
// |            for misalignment / out-of-range error reporting.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module dmem_lsu #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  import dmem_pkg::*;

  localparam int AW = $clog2(DEPTH);

  dmem_state_t r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_we, r_uns;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_commit, w_accept;
  logic        w_sel_we, w_sel_uns;
  logic [1:0]  w_sel_size;
  logic [31:0] w_sel_addr, w_sel_wdata;
  logic [2:0]  w_nbytes;
  logic        w_err;
  logic [AW-1:0] w_base;
  logic [3:0]  w_be;
  logic [31:0] w_rd, w_load;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state, handshake outputs and commit strobe.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    w_commit  = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            w_next   = RESP;
            w_commit = 1'b1;
          end else begin
            w_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (r_cnt == 4'd1) begin
          w_next   = RESP;
          w_commit = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_accept = req_valid && (r_state == IDLE);

  // A zero-latency commit happens on the accept edge, before the request
  // registers hold anything, so the live request is used in IDLE.
  assign w_sel_we    = (r_state == IDLE) ? req_we       : r_we;
  assign w_sel_uns   = (r_state == IDLE) ? req_unsigned : r_uns;
  assign w_sel_size  = (r_state == IDLE) ? req_size     : r_size;
  assign w_sel_addr  = (r_state == IDLE) ? req_addr     : r_addr;
  assign w_sel_wdata = (r_state == IDLE) ? req_wdata    : r_wdata;

  // Request capture and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_cnt   <= 4'(WAIT_CYCLES);
      r_we    <= req_we;
      r_uns   <= req_unsigned;
      r_size  <= req_size;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign w_nbytes = size_bytes(w_sel_size);

`ifdef DMEM_ALIGN_CHECK_EN
  logic [32:0] w_last;
  // Last touched byte in 33 bits so an address near 2^32 cannot wrap.
  assign w_last = {1'b0, w_sel_addr} + {30'd0, w_nbytes} - 33'd1;
  assign w_err  = (w_sel_size == 2'b11) ||
                  (w_sel_size == SZ_HALF && w_sel_addr[0]) ||
                  (w_sel_size == SZ_WORD && w_sel_addr[1:0] != 2'b00) ||
                  (w_last >= 33'(DEPTH));
  assign w_base = w_sel_addr[AW-1:0];
`else
  logic w_unused_addr;
  assign w_unused_addr = ^w_sel_addr[31:AW];
  assign w_err = 1'b0;
  // Silently align and wrap the address instead of reporting errors.
  always_comb begin
    w_base = w_sel_addr[AW-1:0];
    if (w_nbytes == 3'd4)      w_base = w_sel_addr[AW-1:0] & ~AW'(3);
    else if (w_nbytes == 3'd2) w_base = w_sel_addr[AW-1:0] & ~AW'(1);
  end
`endif

  assign w_be = (w_nbytes == 3'd1) ? 4'b0001 :
                (w_nbytes == 3'd2) ? 4'b0011 : 4'b1111;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (w_commit && w_sel_we && !w_err),
    .be    (w_be),
    .waddr (w_base),
    .wdata (w_sel_wdata),
    .raddr (w_base),
    .rdata (w_rd)
  );

  // Little-endian lanes are already in place; only extension remains.
  always_comb begin
    w_load = w_rd;
    if (w_nbytes == 3'd1)      w_load = {{24{!w_sel_uns && w_rd[7]}},  w_rd[7:0]};
    else if (w_nbytes == 3'd2) w_load = {{16{!w_sel_uns && w_rd[15]}}, w_rd[15:0]};
  end

  // Response registers, written only at commit so they stay stable in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_commit) begin
      r_rdata <= (w_err || w_sel_we) ? 32'd0 : w_load;
      r_err   <= w_err;
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_dmem_lsu                                               |
// | Brief    : Directed self-checking bench for dmem_lsu with a          |
// |            byte-array reference model and a per-cycle monitor.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_dmem_lsu;

  localparam int DEPTH       = 256;
  localparam int WAIT_CYCLES = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem_m [DEPTH];
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_err   = 1'b0;

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // Reference: applies the access to the byte model and returns the response.
  function automatic void model_access(input logic we, input logic [1:0] sz, input logic uns,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rd, output logic err);
    int n, a;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
`ifdef DMEM_ALIGN_CHECK_EN
    err = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0) ||
          (longint'(addr) + n - 1 >= DEPTH);
    a = int'(addr % DEPTH);
`else
    err = 1'b0;
    a = int'(addr % DEPTH);
    if (n == 2) a = a - (a % 2);
    if (n == 4) a = a - (a % 4);
`endif
    rd = 32'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mem_m[(a + i) % DEPTH] = wdata[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[(a + i) % DEPTH];
        if (!uns && n < 4 && v[8*n-1]) for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        rd = v;
      end
    end
  endfunction

  // Issue one request, check latency, take the response.
  task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got_rd, output logic got_err);
    int g, lat;
    logic [31:0] m_rd;
    logic m_err;
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 50) begin @(posedge clk); #1; g++; end
    if (g >= 50) chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
    model_access(we, sz, uns, addr, wdata, m_rd, m_err);
    exp_rdata = m_rd; exp_err = m_err;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("latency", 32'(lat), 32'(WAIT_CYCLES));
    got_rd = rsp_rdata; got_err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("ready_after_rsp", {31'd0, req_ready}, 32'd1);
  endtask

  // Compare DUT response against the model whenever a response is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        chk("mon_rdata", rsp_rdata, exp_rdata);
        chk("mon_err", {31'd0, rsp_err}, {31'd0, exp_err});
      end
      chk("mon_ready_vs_valid", {31'd0, req_ready && rsp_valid}, 32'd0);
    end
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] m_rd;
    logic        m_err;
    int          g;

    for (int k = 0; k < DEPTH; k++) mem_m[k] = k[7:0];

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    access(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, er);
    chk("init_word0", rd, 32'h03020100);
    chk("init_word0_err", {31'd0, er}, 32'd0);

    access(1'b1, 2'd0, 1'b0, 32'h4, 32'hFFF, rd, er);
    chk("st_byte_rdata", rd, 32'h0);
    access(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, rd, er);
    chk("ld_word4", rd, 32'h070605FF);
    access(1'b0, 2'd0, 1'b0, 32'h4, 32'h0, rd, er);
    chk("ld_sbyte4", rd, 32'hFFFFFFFF);
    access(1'b0, 2'd0, 1'b1, 32'h4, 32'h0, rd, er);
    chk("ld_ubyte4", rd, 32'h000000FF);

    access(1'b1, 2'd1, 1'b0, 32'h2, 32'h8001, rd, er);
    access(1'b0, 2'd1, 1'b0, 32'h2, 32'h0, rd, er);
    chk("ld_shalf2", rd, 32'hFFFF8001);
    access(1'b0, 2'd1, 1'b1, 32'h2, 32'h0, rd, er);
    chk("ld_uhalf2", rd, 32'h00008001);
    access(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, er);
    chk("ld_word0_after_half", rd, 32'h80010100);

    access(1'b0, 2'd0, 1'b1, 32'(DEPTH - 1), 32'h0, rd, er);
    chk("ld_last_byte", rd, 32'h000000FF);
    chk("ld_last_byte_err", {31'd0, er}, 32'd0);

    access(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("mis_word_err", {31'd0, er}, 32'd1);
    chk("mis_word_rdata", rd, 32'h0);
`endif
    access(1'b1, 2'd2, 1'b0, 32'(DEPTH - 2), 32'hDEADBEEF, rd, er);
    access(1'b0, 2'd2, 1'b0, 32'(DEPTH - 4), 32'h0, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("oor_store_kept", rd, 32'hFFFEFDFC);
`endif
    access(1'b0, 2'd1, 1'b0, 32'(DEPTH - 1), 32'h0, rd, er);
    access(1'b0, 2'd3, 1'b0, 32'h8, 32'h0, rd, er);
    access(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0, rd, er);

    // Back-pressure: hold the response for five cycles with a competing request.
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h8; req_wdata = 32'h0;
    req_valid = 1'b1;
    model_access(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, m_rd, m_err);
    exp_rdata = m_rd; exp_err = m_err;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEBABE;
    g = 0;
    while (!rsp_valid && g < 40) begin @(posedge clk); #1; g++; end
    if (g >= 40) chk("bp_valid_timeout", {31'd0, rsp_valid}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, 32'h0B0A0908);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er);
    chk("bp_ignored_store", rd, 32'h23222120);

    // Reset during BUSY drops the pending store.
    req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'hAABBCCDD;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("busy_req_ready", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #2;
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er);
    chk("abort_store_dropped", rd, 32'h13121110);

    // Reset during RESP discards the response.
    req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0; req_valid = 1'b1;
    model_access(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, m_rd, m_err);
    exp_rdata = m_rd; exp_err = m_err;
    @(posedge clk); #1;
    req_valid = 1'b0;
    g = 0;
    while (!rsp_valid && g < 40) begin @(posedge clk); #1; g++; end
    if (g >= 40) chk("resp_valid_timeout", {31'd0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("resp_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("resp_rst_rdata", rsp_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, er);
    chk("mem_persists", rd, 32'h80010100);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
